// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults, memory select codes and the ReLU helper for the CNN datapath
// Contents: DATA_W_DEF/OUT_W_DEF widths, SEL_PLANAR_BASE/SEL_FLAT memory selects,
// mode_e frame layout, relu() on a 32-bit signed value (callers size-cast in and out).
package cnn_pkg;
  localparam int DATA_W_DEF = 19;
  localparam int OUT_W_DEF = 20;
  localparam logic [2:0] SEL_PLANAR_BASE = 3'd1;
  localparam logic [2:0] SEL_FLAT = 3'd3;
  typedef enum logic {MODE_PLANAR = 1'b0, MODE_FLAT = 1'b1} mode_e;
  function automatic logic signed [31:0] relu(input logic signed [31:0] x);
    return x < 0 ? '0 : x;
  endfunction
endpackage

// File: rtl/pool_lane.sv
// pool_lane: one channel of 2x2/stride-2 max-pool with ReLU, fed in raster order
// Ports: clk, reset (async, active-high); i_en beat accepted; i_row_odd/i_col_odd beat parity;
// i_idx pooled column (col/2); i_x signed sample; o_relu = ReLU(max of 2x2 block), valid on closing beat.
module pool_lane
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W = 64,
  localparam int IW = $clog2(IMG_W / 2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_en,
  input  logic                     i_row_odd,
  input  logic                     i_col_odd,
  input  logic [IW-1:0]            i_idx,
  input  logic signed [DATA_W-1:0] i_x,
  output logic [DATA_W-1:0]        o_relu
);
  logic signed [DATA_W-1:0] pair_q, pair_d, hmax, vmax;
  logic signed [DATA_W-1:0] lb_q [IMG_W/2];
  logic signed [DATA_W-1:0] lb_d [IMG_W/2];
  // pair register holds every even-column sample; the line buffer keeps the even row's pair max
  assign hmax = pair_q > i_x ? pair_q : i_x;
  assign vmax = hmax > lb_q[i_idx] ? hmax : lb_q[i_idx];
  assign o_relu = DATA_W'(relu(32'(vmax)));
  always_comb begin
    pair_d = pair_q;
    lb_d = lb_q;
    if (i_en & ~i_col_odd) pair_d = i_x;
    if (i_en & i_col_odd & ~i_row_odd) lb_d[i_idx] = hmax;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pair_q <= '0;
      lb_q <= '{default: '0};
    end else begin
      pair_q <= pair_d;
      lb_q <= lb_d;
    end
endmodule

// File: rtl/maxpool_relu_writer.sv
// maxpool_relu_writer: ReLU + 2x2 max-pool over CH channels, serialised into layer memory writes
// Ports: clk, reset (async, active-high); i_valid/o_ready beat handshake; i_data CH packed samples;
// i_mode 0 planar / 1 flattened (latched on first beat); o_wr/o_addr/o_data/o_sel memory write;
// o_busy frame in progress; o_done pulse with the frame's last write.
module maxpool_relu_writer
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int IMG_W = 64,
  parameter int CH = 2,
  parameter int ADDR_W = 12,
  parameter logic [2:0] FLAT_SEL = SEL_FLAT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CH*DATA_W-1:0] i_data,
  input  logic                 i_mode,
  output logic                 o_wr,
  output logic [ADDR_W-1:0]    o_addr,
  output logic [OUT_W-1:0]     o_data,
  output logic [2:0]           o_sel,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int CW = $clog2(IMG_W);
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [2:0] pend_cnt_q, pend_cnt_d, ch;
  logic [ADDR_W-1:0] pend_p_q, pend_p_d, o_addr_q, o_addr_d;
  mode_e mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic pend_last_q, pend_last_d, open_q, open_d, busy_q, busy_d;
  logic o_wr_q, o_wr_d, o_done_q, o_done_d;
  logic [OUT_W-1:0] o_data_q, o_data_d;
  logic [2:0] o_sel_q, o_sel_d;
  logic [DATA_W-1:0] lane_relu [CH];
  logic [DATA_W-1:0] pend_val_q [CH];
  logic [DATA_W-1:0] pend_val_d [CH];
  logic [DATA_W-1:0] val;
  logic accept, closing, col_end, row_end, first, last;
  assign closing = row_q[0] & col_q[0];
  assign col_end = col_q == CW'(IMG_W - 1);
  assign row_end = row_q == CW'(IMG_W - 1);
  assign first = (col_q == '0) & (row_q == '0);
  assign last = col_end & row_end;
  // a closing beat may only land once the drain frees the pending buffer on that same edge
  assign o_ready = ~(closing & (pend_cnt_q > 3'd1));
  assign accept = i_valid & o_ready;
  assign ch = 3'(CH) - pend_cnt_q;
  assign {o_wr, o_addr, o_data, o_sel, o_busy, o_done} = {o_wr_q, o_addr_q, o_data_q, o_sel_q, busy_q, o_done_q};
  for (genvar l = 0; l < CH; l++) begin : g_lane
    pool_lane #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lane (
      .clk(clk),
      .reset(reset),
      .i_en(accept),
      .i_row_odd(row_q[0]),
      .i_col_odd(col_q[0]),
      .i_idx(col_q[CW-1:1]),
      .i_x(i_data[l*DATA_W +: DATA_W]),
      .o_relu(lane_relu[l])
    );
  end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    mode_d = mode_q;
    open_d = open_q;
    busy_d = busy_q;
    pend_cnt_d = pend_cnt_q;
    pend_p_d = pend_p_q;
    pend_mode_d = pend_mode_q;
    pend_last_d = pend_last_q;
    pend_val_d = pend_val_q;
    o_wr_d = 1'b0;
    o_done_d = 1'b0;
    o_addr_d = o_addr_q;
    o_data_d = o_data_q;
    o_sel_d = o_sel_q;
    val = '0;
    for (int i = 0; i < CH; i++) if (ch == 3'(i)) val = pend_val_q[i];
    if (pend_cnt_q != 3'd0) begin
      o_wr_d = 1'b1;
      o_data_d = OUT_W'(val);
      o_sel_d = pend_mode_q == MODE_FLAT ? FLAT_SEL : SEL_PLANAR_BASE + ch;
      o_addr_d = pend_mode_q == MODE_FLAT ? pend_p_q * ADDR_W'(CH) + ADDR_W'(ch) : pend_p_q;
      o_done_d = pend_last_q & (pend_cnt_q == 3'd1);
      pend_cnt_d = pend_cnt_q - 3'd1;
    end
    // busy only falls after the final write if no newer frame has already opened
    if (o_done_q & ~open_q) busy_d = 1'b0;
    if (accept) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) row_d = row_end ? '0 : row_q + 1'b1;
      if (first) begin
        mode_d = mode_e'(i_mode);
        open_d = 1'b1;
        busy_d = 1'b1;
      end
      if (last) open_d = 1'b0;
      if (closing) begin
        pend_cnt_d = 3'(CH);
        pend_val_d = lane_relu;
        pend_p_d = ADDR_W'(row_q[CW-1:1]) * ADDR_W'(IMG_W / 2) + ADDR_W'(col_q[CW-1:1]);
        pend_mode_d = mode_q;
        pend_last_d = last;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      mode_q <= MODE_PLANAR;
      open_q <= 1'b0;
      busy_q <= 1'b0;
      pend_cnt_q <= '0;
      pend_p_q <= '0;
      pend_mode_q <= MODE_PLANAR;
      pend_last_q <= 1'b0;
      pend_val_q <= '{default: '0};
      o_wr_q <= 1'b0;
      o_done_q <= 1'b0;
      o_addr_q <= '0;
      o_data_q <= '0;
      o_sel_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      mode_q <= mode_d;
      open_q <= open_d;
      busy_q <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      pend_p_q <= pend_p_d;
      pend_mode_q <= pend_mode_d;
      pend_last_q <= pend_last_d;
      pend_val_q <= pend_val_d;
      o_wr_q <= o_wr_d;
      o_done_q <= o_done_d;
      o_addr_q <= o_addr_d;
      o_data_q <= o_data_d;
      o_sel_q <= o_sel_d;
    end
endmodule

// File: tb/tb_maxpool_relu_writer.sv
// tb_maxpool_relu_writer: checks 4x4 frames on a CH=4 and a CH=2 instance against a pooled-frame model
module tb_maxpool_relu_writer;
  localparam int DW = 19;
  typedef struct {logic [2:0] sel; logic [11:0] addr; logic [19:0] data; logic done;} wr_t;
  typedef struct {int a; int b; int c; int d; int exp;} vec_t;
  logic clk = 0, reset = 1, i_valid = 0, i_mode = 0;
  logic [4*DW-1:0] i_data = '0;
  logic rdy4, wr4, busy4, done4, rdy2, wr2, busy2, done2, v2;
  logic [11:0] addr4, addr2;
  logic [19:0] data4, data2;
  logic [2:0] sel4, sel2;
  wr_t got4[$], got2[$], exp4[$], exp2[$];
  int px[4][4][4];
  int errors = 0, checks = 0, stalls = 0, r2_low = 0, busy_drop = 0;
  bit watch = 0;
  vec_t tv[5];
  always #5 clk = ~clk;
  assign v2 = i_valid & rdy4;
  maxpool_relu_writer #(.DATA_W(DW), .OUT_W(20), .IMG_W(4), .CH(4), .ADDR_W(12), .FLAT_SEL(3'd3)) dut4 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdy4), .i_data(i_data), .i_mode(i_mode),
    .o_wr(wr4), .o_addr(addr4), .o_data(data4), .o_sel(sel4), .o_busy(busy4), .o_done(done4));
  maxpool_relu_writer #(.DATA_W(DW), .OUT_W(20), .IMG_W(4), .CH(2), .ADDR_W(12), .FLAT_SEL(3'd3)) dut2 (
    .clk(clk), .reset(reset), .i_valid(v2), .o_ready(rdy2), .i_data(i_data[2*DW-1:0]), .i_mode(i_mode),
    .o_wr(wr2), .o_addr(addr2), .o_data(data2), .o_sel(sel2), .o_busy(busy2), .o_done(done2));
  always @(negedge clk) begin
    if (wr4) got4.push_back('{sel4, addr4, data4, done4});
    if (wr2) got2.push_back('{sel2, addr2, data2, done2});
    if (watch && !busy4) busy_drop++;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic logic [35:0] pk(input wr_t w);
    return {w.sel, w.addr, w.data, w.done};
  endfunction
  function automatic logic [4*DW-1:0] pack(input int r, input int c);
    logic [4*DW-1:0] v;
    for (int k = 0; k < 4; k++) begin
      int t = px[k][r][c];
      v[k*DW +: DW] = t[DW-1:0];
    end
    return v;
  endfunction
  task automatic push_exp(input logic m);
    for (int n = 2; n <= 4; n += 2)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < n; k++) begin
          int mx = px[k][(p/2)*2][(p%2)*2];
          wr_t e;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (px[k][(p/2)*2+dr][(p%2)*2+dc] > mx) mx = px[k][(p/2)*2+dr][(p%2)*2+dc];
          if (mx < 0) mx = 0;
          e.sel = m ? 3'd3 : 3'(k + 1);
          e.addr = m ? 12'(p * n + k) : 12'(p);
          e.data = 20'(mx);
          e.done = (p == 3) && (k == n - 1);
          if (n == 4) exp4.push_back(e); else exp2.push_back(e);
        end
  endtask
  task automatic beat(input logic [4*DW-1:0] d, input logic m);
    int w = 0;
    i_valid = 1;
    i_data = d;
    i_mode = m;
    while (!rdy4) begin
      stalls++;
      @(negedge clk);
      if (++w > 20) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: o_ready stuck low for %0d cycles, required high within 20", w);
        break;
      end
    end
    if (!rdy2) r2_low++;
    @(negedge clk);
    i_valid = 0;
  endtask
  task automatic send_frame(input logic m, input bit gaps, input bit toggle, input int nb);
    for (int k = 0; k < nb; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      beat(pack(k / 4, k % 4), k == 0 ? m : toggle ? ~m : 1'($urandom_range(0, 1)));
    end
    if (nb == 16) push_exp(m);
  endtask
  task automatic wait_idle();
    int w = 0;
    while ((busy4 || busy2) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w == 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: o_busy still high after %0d cycles, required low", w);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic cmp_q(input string nm);
    chk({nm, " count4"}, 64'(got4.size()), 64'(exp4.size()));
    chk({nm, " count2"}, 64'(got2.size()), 64'(exp2.size()));
    for (int i = 0; i < exp4.size() && i < got4.size(); i++)
      chk($sformatf("%s w4[%0d] {sel,addr,data,done}", nm, i), 64'(pk(got4[i])), 64'(pk(exp4[i])));
    for (int i = 0; i < exp2.size() && i < got2.size(); i++)
      chk($sformatf("%s w2[%0d] {sel,addr,data,done}", nm, i), 64'(pk(got2[i])), 64'(pk(exp2[i])));
    got4.delete(); got2.delete(); exp4.delete(); exp2.delete();
  endtask
  task automatic plan_frame();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        px[0][r][c] = r * 4 + c;
        px[1][r][c] = -1;
        px[2][r][c] = 15 - (r * 4 + c);
        px[3][r][c] = int'($urandom_range(0, 1000)) - 500;
      end
  endtask
  task automatic rand_frame();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) px[k][r][c] = int'($urandom_range(0, 524287)) - 262144;
  endtask
  initial begin
    tv[0] = '{-8, -3, -5, -1, 0};
    tv[1] = '{-2, 3, 1, -7, 3};
    tv[2] = '{262143, -262144, 0, 5, 262143};
    tv[3] = '{-262144, -262144, -262144, -262144, 0};
    tv[4] = '{7, 7, 7, -7, 7};
    repeat (2) @(negedge clk);
    chk("reset outputs {rdy4,wr,addr,data,sel,busy,done}", {rdy4, wr4, addr4, data4, sel4, busy4, done4}, {1'b1, 38'd0});
    chk("reset rdy2", 64'(rdy2), 64'd1);
    reset = 0;
    @(negedge clk);
    plan_frame();
    stalls = 0;
    send_frame(0, 0, 0, 16);
    chk("ch4 stall cycles", 64'(stalls), 64'd4);
    chk("p2 ch3 write at closing edge {wr,addr,sel,done}", {wr4, addr4, sel4, done4}, {1'b1, 12'd2, 3'd4, 1'b0});
    repeat (3) @(negedge clk);
    chk("no early done", 64'(done4), 64'd0);
    @(negedge clk);
    chk("last write {wr,addr,sel,done,busy}", {wr4, addr4, sel4, done4, busy4}, {1'b1, 12'd3, 3'd4, 1'b1, 1'b1});
    @(negedge clk);
    chk("busy low after done", {wr4, busy4}, 2'b00);
    wait_idle();
    cmp_q("plan planar");
    send_frame(1, 1, 0, 16);
    wait_idle();
    cmp_q("plan flat");
    rand_frame();
    send_frame(0, 0, 1, 16);
    watch = 1;
    plan_frame();
    send_frame(1, 0, 1, 16);
    watch = 0;
    chk("b2b busy drop", 64'(busy_drop), 64'd0);
    wait_idle();
    cmp_q("back-to-back");
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) px[k][r][c] = 0;
      for (int k = 0; k < 4; k++) begin
        px[k][0][0] = tv[i].a;
        px[k][0][1] = tv[i].b;
        px[k][1][0] = tv[i].c;
        px[k][1][1] = tv[i].d;
      end
      send_frame(0, 0, 0, 16);
      wait_idle();
      chk($sformatf("vec%0d data4", i), 64'(got4.size() > 0 ? got4[0].data : 20'hfffff), 64'(tv[i].exp));
      chk($sformatf("vec%0d data2", i), 64'(got2.size() > 0 ? got2[0].data : 20'hfffff), 64'(tv[i].exp));
      cmp_q($sformatf("vec%0d", i));
    end
    for (int f = 0; f < 6; f++) begin
      rand_frame();
      send_frame(1'($urandom_range(0, 1)), 1, 0, 16);
    end
    wait_idle();
    cmp_q("random");
    rand_frame();
    send_frame(0, 1, 0, 9);
    reset = 1;
    #1;
    chk("mid-frame reset outputs {rdy4,wr,busy,done}", {rdy4, wr4, busy4, done4}, 4'b1000);
    @(negedge clk);
    got4.delete();
    got2.delete();
    reset = 0;
    repeat (6) @(negedge clk);
    chk("no writes after abort", 64'(got4.size() + got2.size()), 64'd0);
    plan_frame();
    send_frame(0, 0, 0, 16);
    wait_idle();
    cmp_q("after reset");
    chk("ch2 ready never low", 64'(r2_low), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
